// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: register-address width, controller state encoding and a
// saturating-increment helper shared by the hazard controller files.
`default_nettype none

package hazard_ctrl_pkg;

  localparam int RegAddrWidth = 5;

  typedef enum logic [0:0] {
    HZ_IDLE    = 1'b0,
    HZ_MD_BUSY = 1'b1
  } hz_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_hz_stall_timer.sv
// hz_stall_timer: loadable down-counter with zero flag; stops at zero.
`default_nettype none

module hz_stall_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble, multi-cycle mul/div stall and branch squash control.
// Optional HAZARD_STATS_EN adds three saturating 32-bit stall/flush counters.
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RegAddrWidth-1:0] raddr_1_ID,
  input  logic [RegAddrWidth-1:0] raddr_2_ID,
  input  logic                    re_1_ID,
  input  logic                    re_2_ID,
  input  logic                    ReadMem_EX,
  input  logic                    WriteReg_EX,
  input  logic [RegAddrWidth-1:0] waddr_EX,
  input  logic                    md_start_EX,
  input  logic                    branch_taken_ID,
  output logic                    hold_PC,
  output logic                    hold_IF_ID,
  output logic                    hold_ID_EX,
  output logic                    bubble_ID_EX,
  output logic                    flush_IF_ID,
  output logic                    md_busy,
  output logic                    md_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stat_load_stalls,
  output logic [31:0]             stat_md_stalls,
  output logic [31:0]             stat_flushes
`endif
);

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load, cnt_dec;
  logic             luh;
  logic             h_pc, h_if_id, h_id_ex, bub, done, flush;

  hz_stall_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (MD_LOAD),
    .dec   (cnt_dec),
    .cnt   (cnt),
    .zero  (cnt_zero)
  );

  assign luh = ReadMem_EX && WriteReg_EX && (waddr_EX != '0) &&
               ((re_1_ID && (raddr_1_ID == waddr_EX)) ||
                (re_2_ID && (raddr_2_ID == waddr_EX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HZ_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    h_pc     = 1'b0;
    h_if_id  = 1'b0;
    h_id_ex  = 1'b0;
    bub      = 1'b0;
    done     = 1'b0;
    case (state_q)
      HZ_IDLE: begin
        if (md_start_EX) begin
          h_pc     = 1'b1;
          h_if_id  = 1'b1;
          h_id_ex  = 1'b1;
          cnt_load = 1'b1;
          state_d  = HZ_MD_BUSY;
        end else if (luh) begin
          h_pc    = 1'b1;
          h_if_id = 1'b1;
          bub     = 1'b1;
        end
      end
      HZ_MD_BUSY: begin
        // Final EX cycle releases the holds so the pipeline advances at this edge.
        if (!cnt_zero) begin
          h_pc    = 1'b1;
          h_if_id = 1'b1;
          h_id_ex = 1'b1;
          cnt_dec = 1'b1;
        end else begin
          done    = 1'b1;
          state_d = HZ_IDLE;
        end
      end
      default: state_d = HZ_IDLE;
    endcase
  end

  assign flush = branch_taken_ID && !h_if_id;

  // Outputs are forced low for the whole time reset is asserted.
  assign hold_PC      = !rst && h_pc;
  assign hold_IF_ID   = !rst && h_if_id;
  assign hold_ID_EX   = !rst && h_id_ex;
  assign bubble_ID_EX = !rst && bub;
  assign flush_IF_ID  = !rst && flush;
  assign md_busy      = !rst && (state_q == HZ_MD_BUSY);
  assign md_done      = !rst && done;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_load_stalls <= '0;
      stat_md_stalls   <= '0;
      stat_flushes     <= '0;
    end else begin
      stat_load_stalls <= sat_inc(stat_load_stalls, bubble_ID_EX);
      stat_md_stalls   <= sat_inc(stat_md_stalls, hold_ID_EX);
      stat_flushes     <= sat_inc(stat_flushes, flush_IF_ID);
    end
  end
`endif

endmodule

`default_nettype wire
